// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared constants for the modulo counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter of mod_counter
//   DEF_WIDTH            : default counter register width in bits
// -----------------------------------------------------------------------------
package calc_pkg;

   localparam int MODE_WRAP = 32'sd0;
   localparam int MODE_SAT  = 32'sd1;
   localparam int DEF_WIDTH = 32'sd8;

endpackage : calc_pkg

// File: rtl/mod_counter_if.sv
// -----------------------------------------------------------------------------
// mod_counter_if
// Control and status bundle of one modulo counter.
//   enable, up_dn, clear, load, load_val : requests from the user (master)
//   q, tc, carry, borrow, sat, load_err  : counter state and flags (slave)
// Clock and reset are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface mod_counter_if
   import calc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             enable;
   logic             up_dn;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             carry;
   logic             borrow;
   logic             sat;
   logic             load_err;

   modport master (
      output enable, up_dn, clear, load, load_val,
      input  q, tc, carry, borrow, sat, load_err
   );

   modport slave (
      input  enable, up_dn, clear, load, load_val,
      output q, tc, carry, borrow, sat, load_err
   );

endinterface : mod_counter_if

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Up/down modulo-MODULUS counter with clear, load, wrap or saturate at the
// range ends, and cascade-friendly terminal count.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   bus    : mod_counter_if.slave
//            in  : enable, up_dn, clear, load, load_val
//            out : q (registered), tc (combinational),
//                  carry / borrow / load_err (registered one-cycle pulses),
//                  sat (registered, high while held at a range end)
// Priority at each edge: reset > clear > load > enable.
// -----------------------------------------------------------------------------
module mod_counter
   import calc_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MODULUS  = 32'sd1 << WIDTH,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic         clk,
   input  logic         reset,
   mod_counter_if.slave bus
);

   // Reject impossible configurations at elaboration time.
   if (WIDTH < 32'sd1) begin : g_bad_width
      $error("mod_counter: WIDTH must be at least 1");
   end
   if ((MODULUS < 32'sd2) || (longint'(MODULUS) > (64'sd1 <<< WIDTH))) begin : g_bad_modulus
      $error("mod_counter: MODULUS must lie in 2 .. 2**WIDTH");
   end

   // The modulus itself needs WIDTH+1 bits when MODULUS == 2**WIDTH.
   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(32'd1);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 32'sd1);

   // Registers start at zero so q reads 0 even before the first reset.
   logic [WIDTH-1:0] r_q        = {WIDTH{1'b0}};
   logic             r_carry    = 1'b0;
   logic             r_borrow   = 1'b0;
   logic             r_sat      = 1'b0;
   logic             r_load_err = 1'b0;

   logic [WIDTH:0]   w_up;
   logic [WIDTH:0]   w_dn;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_carry_nxt;
   logic             w_borrow_nxt;
   logic             w_sat_nxt;
   logic             w_load_err_nxt;

   // One extra bit: w_up reaching MOD_X marks the top end, and the MSB of
   // w_dn going high marks an underflow below zero.
   assign w_up = {1'b0, r_q} + ONE_X;
   assign w_dn = {1'b0, r_q} - ONE_X;

   // Next-state selection following the clear > load > enable priority.
   always_comb begin
      w_q_nxt        = r_q;
      w_carry_nxt    = 1'b0;
      w_borrow_nxt   = 1'b0;
      w_sat_nxt      = r_sat;
      w_load_err_nxt = 1'b0;
      if (bus.clear) begin
         w_q_nxt   = {WIDTH{1'b0}};
         w_sat_nxt = 1'b0;
      end else if (bus.load) begin
         w_sat_nxt = 1'b0;
         if ({1'b0, bus.load_val} < MOD_X) begin
            w_q_nxt = bus.load_val;
         end else begin
            // Out-of-range loads clamp to the top of the range.
            w_q_nxt        = MAX_Q;
            w_load_err_nxt = 1'b1;
         end
      end else if (bus.enable) begin
         if (bus.up_dn) begin
            if (w_up != MOD_X) begin
               w_q_nxt   = w_up[WIDTH-1:0];
               w_sat_nxt = 1'b0;
            end else if (SATURATE == MODE_SAT) begin
               w_sat_nxt = 1'b1;
            end else begin
               w_q_nxt     = {WIDTH{1'b0}};
               w_carry_nxt = 1'b1;
               w_sat_nxt   = 1'b0;
            end
         end else begin
            if (!w_dn[WIDTH]) begin
               w_q_nxt   = w_dn[WIDTH-1:0];
               w_sat_nxt = 1'b0;
            end else if (SATURATE == MODE_SAT) begin
               w_sat_nxt = 1'b1;
            end else begin
               w_q_nxt      = MAX_Q;
               w_borrow_nxt = 1'b1;
               w_sat_nxt    = 1'b0;
            end
         end
      end else begin
         // Idle: count and sat hold, pulses stay low.
         w_q_nxt = r_q;
      end
   end

   // Single registered stage; reset overrides every request and drops pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q        <= {WIDTH{1'b0}};
         r_carry    <= 1'b0;
         r_borrow   <= 1'b0;
         r_sat      <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_q        <= w_q_nxt;
         r_carry    <= w_carry_nxt;
         r_borrow   <= w_borrow_nxt;
         r_sat      <= w_sat_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   assign bus.q        = r_q;
   assign bus.carry    = r_carry;
   assign bus.borrow   = r_borrow;
   assign bus.sat      = r_sat;
   assign bus.load_err = r_load_err;
   // tc ignores enable so a following stage can use enable & tc.
   assign bus.tc       = bus.up_dn ? (r_q == MAX_Q) : (r_q == {WIDTH{1'b0}});

endmodule : mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter register width in bits; SHALL be >= 1.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1; SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 enable  input  1  count step enable.
REQ-007 up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 clear  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous load of load_val.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 q  output  WIDTH  registered count.
REQ-012 tc  output  1  combinational terminal count for current direction.
REQ-013 carry  output  1  registered one-cycle pulse on up-wrap.
REQ-014 borrow  output  1  registered one-cycle pulse on down-wrap.
REQ-015 sat  output  1  registered; high while held at a range end by SATURATE=1.
REQ-016 load_err  output  1  registered one-cycle pulse on an out-of-range load.

Function
REQ-017 Per-edge priority SHALL be: reset, then clear, then load, then enable; lower-priority requests in the same cycle are ignored.
REQ-018 clear SHALL set q to 0 and deassert sat in the next cycle.
REQ-019 A load with load_val < MODULUS SHALL set q = load_val; with load_val >= MODULUS, q = MODULUS-1 and load_err pulses for one cycle.
REQ-020 enable=1, up_dn=1, q < MODULUS-1: q SHALL become q+1.
REQ-021 enable=1, up_dn=0, q > 0: q SHALL become q-1.
REQ-022 Up at q = MODULUS-1 with SATURATE=0: q SHALL become 0 and carry pulses high for the following cycle.
REQ-023 Down at q = 0 with SATURATE=0: q SHALL become MODULUS-1 and borrow pulses high for the following cycle.
REQ-024 SATURATE=1 at a range end stepping outward: q SHALL hold, sat SHALL go high, and carry/borrow SHALL stay low.
REQ-025 sat SHALL fall on the first cycle in which q moves off the end, or on clear, load or reset.
REQ-026 tc SHALL be (up_dn ? q == MODULUS-1 : q == 0), independent of enable; this allows cascading via next.enable = enable & tc.
REQ-027 enable=0 with no clear or load: q SHALL hold, and carry, borrow and load_err SHALL be 0.
REQ-028 Width rule: the internal next-count calculation SHALL be WIDTH+1 bits wide; q SHALL never take a value >= MODULUS.
REQ-029 A direction change on any cycle SHALL take effect on that edge with no latency penalty.

Reset
REQ-030 reset = 0 at a rising edge SHALL force q = 0 and carry = borrow = sat = load_err = 0, overriding all other inputs.
REQ-031 reset asserted mid-count SHALL discard any pending pulse; no pulse SHALL appear in the cycle after reset.
REQ-032 Power-up register initial value SHALL be 0, so q = 0 before the first reset.

Structure
REQ-033 The shared package calc_pkg SHALL hold the mode constants MODE_WRAP = 0 and MODE_SAT = 1 and the default WIDTH.
REQ-034 The block is a single module with no sub-modules; the next-count and terminal-detect logic is a combinational block feeding one registered stage.
REQ-035 Elaboration SHALL fail on an illegal MODULUS or WIDTH.

Verification
REQ-036 WIDTH=4, MODULUS=10, wrap: 10 up steps from 0 -> q = 1..9 then 0; carry high exactly one cycle after the 9->0 edge.
REQ-037 Same config: down from 0 -> q = 9, borrow one-cycle pulse; tc high at q = 0 while up_dn = 0.
REQ-038 SATURATE=1, MODULUS=10: up at 9 for 3 cycles -> q stays 9, sat high, carry low; one down step -> q = 8, sat low.
REQ-039 load_val = 12, MODULUS=10 -> q = 9 and load_err pulses once; load_val = 5 -> q = 5, no load_err.
REQ-040 clear, load and enable asserted together with q = 7 -> q = 0; reset = 0 with all inputs active -> q = 0 and all flags 0.
REQ-041 Two MODULUS=10 instances cascaded via tc -> the pair counts 00..99 then 00; the upper carry pulses once per 100 enables.
